fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
Instruction-fetch stage of the pipelined RV32I core. It owns the PC register, drives the byte address into the instruction memory (combinational read, 4 KiB window at 0xBFC00000–0xBFC00FFF), and registers the returned word into the IF/ID pipeline register. The hazard unit and EX stage control it through stall, flush and redirect inputs. It feeds the decode stage.

Parameters:
A_WIDTH, 12, instruction-memory byte-address width; the window size is 2**A_WIDTH bytes.
RESET_PC, 32'hBFC00000, PC value after reset; also the window base.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous reset, active low
stall_i  in  1  hold PC and IF/ID (load-use hazard)
flush_i  in  1  insert bubble into IF/ID
redirect_valid_i  in  1  take redirect_pc_i as next PC (taken branch/jump)
redirect_pc_i  in  32  redirect target
imem_addr_o  out  A_WIDTH  byte address to instruction memory, = pc_f_o[A_WIDTH-1:0]
imem_rd_i  in  32  instruction word returned combinationally, same cycle
pc_f_o  out  32  current fetch PC
instr_d_o  out  32  IF/ID instruction
pc_d_o  out  32  IF/ID PC
pc_plus4_d_o  out  32  IF/ID PC+4
valid_d_o  out  1  IF/ID holds a real instruction
fault_d_o  out  1  IF/ID entry came from an illegal fetch PC
fetch_count_o  out  32  number of valid instructions captured into IF/ID

Behaviour:
- Reset (rst_n low, asynchronous, takes effect immediately, mid-operation included):
  - pc_f_o = RESET_PC.
  - instr_d_o = 32'h00000013 (NOP).
  - pc_d_o = 0, pc_plus4_d_o = 0.
  - valid_d_o = 0, fault_d_o = 0, fetch_count_o = 0.
- Fetch legality is combinational on pc_f_o.
  - illegal = (pc_f_o[31:A_WIDTH] != RESET_PC[31:A_WIDTH]) OR (pc_f_o[1:0] != 0).
- Next-PC priority, evaluated each rising edge:
  1. redirect_valid_i: pc <= redirect_pc_i. Overrides stall_i.
  2. stall_i: pc holds.
  3. Otherwise: pc <= pc + 4. Modulo 2^32; no saturation.
- IF/ID update priority, evaluated each rising edge:
  1. flush_i: instr <= NOP, pc_d <= 0, pc_plus4_d <= 0, valid <= 0, fault <= 0. Flush wins over stall.
  2. stall_i: all IF/ID fields hold.
  3. Otherwise:
     - pc_d <= pc_f_o, pc_plus4_d <= pc_f_o + 4.
     - If illegal: instr <= NOP, valid <= 0, fault <= 1.
     - If legal: instr <= imem_rd_i, valid <= 1, fault <= 0.
- Redirect does not flush by itself. On a taken branch the hazard unit asserts redirect_valid_i and flush_i together.
- fetch_count_o increments by 1 on every edge where IF/ID is loaded with valid = 1. It wraps at 2^32.
- Latency:
  - An instruction at PC p appears on instr_d_o one edge after pc_f_o == p, provided there is no stall or flush on that edge.
  - Redirect-to-fetch latency is one edge. The target's instruction reaches IF/ID on the second edge.
- First cycle after reset release: valid_d_o stays 0 until the first capture edge.
- Window end: PC 0xBFC00FFC fetches legally. The next PC, 0xBFC01000, is illegal and yields fault_d_o = 1. The PC keeps incrementing; the trap path is owned downstream.
- Misaligned redirect target (e.g. 0xBFC00102): the PC is loaded as given and the fetch is flagged illegal. The PC is not rounded.
- Stall with illegal PC: the fault entry is held unchanged in IF/ID.
- imem_rd_i is sampled only on capture edges. Its value during stall or flush is ignored.

Decomposition:
- Shared package fetch_pkg:
  - NOP_INSTR = 32'h00000013.
  - IMEM_BASE = 32'hBFC00000.
  - IMEM_A_WIDTH = 12.
  - Typedef if_id_t: packed struct {instr, pc, pc_plus4, valid, fault}.
- One sub-module: if_id_reg. It is the stall/flush-controlled register of an if_id_t, with asynchronous active-low reset to the bubble value. It is reused as the pattern for later pipeline registers.
- PC logic and counter stay in fetch_stage.

Test Plan:
1. Reset mid-run: drive rst_n low while pc_f_o = 0xBFC00010. Required: same cycle, without a clock edge, pc_f_o = 0xBFC00000, instr_d_o = 0x00000013, valid_d_o = 0, fetch_count_o = 0.
2. Sequential fetch: memory model preloaded with words 0x11111111/0x22222222/0x33333333 at offsets 0/4/8; release reset and run 3 edges. Required: pc_f_o = 0xBFC0000C, instr_d_o = 0x33333333, pc_d_o = 0xBFC00008, pc_plus4_d_o = 0xBFC0000C, fetch_count_o = 3.
3. Stall: stall_i high for 2 edges with pc_f_o = 0xBFC00008. Required: pc_f_o and all IF/ID outputs unchanged and fetch_count_o unchanged. After release, the next edge loads 0x33333333.
4. Redirect+flush: redirect_pc_i = 0xBFC00100 with redirect_valid_i = flush_i = 1 for one edge. Required after that edge: pc_f_o = 0xBFC00100, valid_d_o = 0, instr_d_o = NOP. Required after the next edge: the word at offset 0x100 with pc_d_o = 0xBFC00100.
5. Simultaneous controls:
   - stall_i = flush_i = 1: Required: IF/ID becomes a bubble and the PC holds.
   - stall_i = redirect_valid_i = 1: Required: the PC loads the redirect target.
6. Window edge and misalignment:
   - Redirect to 0xBFC00FFC. Required: a valid capture, then pc_f_o = 0xBFC01000 and the next capture has fault_d_o = 1, valid_d_o = 0, instr_d_o = NOP.
   - Redirect to 0xBFC00102. Required: fault_d_o = 1.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage and its IF/ID register.
package fetch_pkg;

  localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;
  localparam logic [31:0] IMEM_BASE    = 32'hBFC0_0000;
  localparam int          IMEM_A_WIDTH = 12;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        valid;
    logic        fault;
  } if_id_t;

  localparam if_id_t IF_ID_BUBBLE = '{
    instr:    NOP_INSTR,
    pc:       32'h0,
    pc_plus4: 32'h0,
    valid:    1'b0,
    fault:    1'b0
  };

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// Stall/flush-controlled pipeline register holding one IF/ID entry.
// Flush beats stall so a squashed slot never survives a concurrent hold.
module if_id_reg
  import fetch_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   stall_i,
  input  logic   flush_i,
  input  if_id_t d_i,
  output if_id_t q_o
);

  if_id_t entry_q, entry_d;

  always_comb begin
    entry_d = entry_q;
    if (flush_i) begin
      entry_d = IF_ID_BUBBLE;
    end else if (!stall_i) begin
      entry_d = d_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entry_q <= IF_ID_BUBBLE;
    end else begin
      entry_q <= entry_d;
    end
  end

  assign q_o = entry_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, fetch legality check, IF/ID capture
// and a running count of valid instructions handed to decode.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int          A_WIDTH  = IMEM_A_WIDTH,
  parameter logic [31:0] RESET_PC = IMEM_BASE
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall_i,
  input  logic               flush_i,
  input  logic               redirect_valid_i,
  input  logic [31:0]        redirect_pc_i,
  output logic [A_WIDTH-1:0] imem_addr_o,
  input  logic [31:0]        imem_rd_i,
  output logic [31:0]        pc_f_o,
  output logic [31:0]        instr_d_o,
  output logic [31:0]        pc_d_o,
  output logic [31:0]        pc_plus4_d_o,
  output logic               valid_d_o,
  output logic               fault_d_o,
  output logic [31:0]        fetch_count_o
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] count_q, count_d;
  logic        illegal;
  logic        capture;
  if_id_t      cap_entry;
  if_id_t      if_id_q;

  // Out-of-window or misaligned PCs fetch a NOP marked as a fault.
  assign illegal = (pc_q[31:A_WIDTH] != RESET_PC[31:A_WIDTH]) || (pc_q[1:0] != 2'b00);
  assign capture = !flush_i && !stall_i;

  always_comb begin
    pc_d = pc_q + 32'd4;
    if (redirect_valid_i) begin
      pc_d = redirect_pc_i;
    end else if (stall_i) begin
      pc_d = pc_q;
    end
  end

  always_comb begin
    cap_entry.pc       = pc_q;
    cap_entry.pc_plus4 = pc_q + 32'd4;
    cap_entry.instr    = illegal ? NOP_INSTR : imem_rd_i;
    cap_entry.valid    = !illegal;
    cap_entry.fault    = illegal;
  end

  always_comb begin
    count_d = count_q;
    if (capture && !illegal) begin
      count_d = count_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= RESET_PC;
      count_q <= 32'h0;
    end else begin
      pc_q    <= pc_d;
      count_q <= count_d;
    end
  end

  if_id_reg u_if_id_reg (
    .clk     (clk),
    .rst_n   (rst_n),
    .stall_i (stall_i),
    .flush_i (flush_i),
    .d_i     (cap_entry),
    .q_o     (if_id_q)
  );

  assign imem_addr_o   = pc_q[A_WIDTH-1:0];
  assign pc_f_o        = pc_q;
  assign instr_d_o     = if_id_q.instr;
  assign pc_d_o        = if_id_q.pc;
  assign pc_plus4_d_o  = if_id_q.pc_plus4;
  assign valid_d_o     = if_id_q.valid;
  assign fault_d_o     = if_id_q.fault;
  assign fetch_count_o = count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: each driven edge pushes the expected IF/ID
// entry, which is popped and compared one time unit after the edge.
module tb_fetch_stage;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_i, flush_i, redirect_valid_i;
  logic [31:0] redirect_pc_i;
  logic [11:0] imem_addr_o;
  logic [31:0] imem_rd_i;
  logic [31:0] pc_f_o, instr_d_o, pc_d_o, pc_plus4_d_o, fetch_count_o;
  logic        valid_d_o, fault_d_o;

  logic [31:0] mem [0:1023];
  logic [31:0] m_pc, m_cnt;
  if_id_t      m_ifid;
  if_id_t      exp_q[$];
  if_id_t      e;
  if_id_t      obs;
  int          tests = 0;
  int          fails = 0;

  always #5 clk = ~clk;

  assign imem_rd_i = mem[imem_addr_o[11:2]];
  assign obs = {instr_d_o, pc_d_o, pc_plus4_d_o, valid_d_o, fault_d_o};

  fetch_stage dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .stall_i          (stall_i),
    .flush_i          (flush_i),
    .redirect_valid_i (redirect_valid_i),
    .redirect_pc_i    (redirect_pc_i),
    .imem_addr_o      (imem_addr_o),
    .imem_rd_i        (imem_rd_i),
    .pc_f_o           (pc_f_o),
    .instr_d_o        (instr_d_o),
    .pc_d_o           (pc_d_o),
    .pc_plus4_d_o     (pc_plus4_d_o),
    .valid_d_o        (valid_d_o),
    .fault_d_o        (fault_d_o),
    .fetch_count_o    (fetch_count_o)
  );

  task automatic do_reset();
    rst_n = 1'b0;
    stall_i = 1'b0; flush_i = 1'b0; redirect_valid_i = 1'b0; redirect_pc_i = 32'h0;
    m_pc = 32'hBFC0_0000;
    m_cnt = 32'h0;
    m_ifid = '{instr: 32'h13, pc: 32'h0, pc_plus4: 32'h0, valid: 1'b0, fault: 1'b0};
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // Drive one edge and push the model's expected IF/ID entry.
  task automatic drive_edge(input logic st, input logic fl, input logic rv, input logic [31:0] rpc);
    logic   ill;
    if_id_t n;
    stall_i = st; flush_i = fl; redirect_valid_i = rv; redirect_pc_i = rpc;
    ill = (m_pc[31:12] != 20'hBFC00) || (m_pc[1:0] != 2'b00);
    if (fl) begin
      n = '{instr: 32'h13, pc: 32'h0, pc_plus4: 32'h0, valid: 1'b0, fault: 1'b0};
    end else if (st) begin
      n = m_ifid;
    end else begin
      n.pc = m_pc;
      n.pc_plus4 = m_pc + 32'd4;
      n.instr = ill ? 32'h13 : mem[m_pc[11:2]];
      n.valid = !ill;
      n.fault = ill;
      if (!ill) m_cnt = m_cnt + 32'd1;
    end
    m_pc = rv ? rpc : (st ? m_pc : m_pc + 32'd4);
    m_ifid = n;
    exp_q.push_back(n);
    @(posedge clk); #1;
    stall_i = 1'b0; flush_i = 1'b0; redirect_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive_edge(1'b0, 1'b0, 1'b0, 32'h0);
      e = exp_q.pop_front();
      tests++; if (obs !== e) begin fails++; $display("FAIL reset_run[%0d] got=%h exp=%h", i, obs, e); end
    end
    tests++; if (pc_f_o !== 32'hBFC0_0010) begin fails++; $display("FAIL reset_prepc got=%h exp=bfc00010", pc_f_o); end
    #2 rst_n = 1'b0;
    #1;
    tests++; if (pc_f_o !== 32'hBFC0_0000) begin fails++; $display("FAIL reset_pc got=%h exp=bfc00000", pc_f_o); end
    tests++; if (instr_d_o !== 32'h13) begin fails++; $display("FAIL reset_instr got=%h exp=00000013", instr_d_o); end
    tests++; if (valid_d_o !== 1'b0 || fault_d_o !== 1'b0) begin fails++; $display("FAIL reset_flags got=%b%b exp=00", valid_d_o, fault_d_o); end
    tests++; if (pc_d_o !== 32'h0 || pc_plus4_d_o !== 32'h0) begin fails++; $display("FAIL reset_pcd got=%h/%h exp=0/0", pc_d_o, pc_plus4_d_o); end
    tests++; if (fetch_count_o !== 32'h0) begin fails++; $display("FAIL reset_count got=%0d exp=0", fetch_count_o); end
  endtask

  task automatic test_seq();
    do_reset();
    tests++; if (valid_d_o !== 1'b0) begin fails++; $display("FAIL seq_first_valid got=%b exp=0", valid_d_o); end
    for (int i = 0; i < 3; i++) begin
      drive_edge(1'b0, 1'b0, 1'b0, 32'h0);
      e = exp_q.pop_front();
      tests++; if (obs !== e) begin fails++; $display("FAIL seq_ifid[%0d] got=%h exp=%h", i, obs, e); end
    end
    tests++; if (pc_f_o !== 32'hBFC0_000C) begin fails++; $display("FAIL seq_pc got=%h exp=bfc0000c", pc_f_o); end
    tests++; if (instr_d_o !== 32'h3333_3333) begin fails++; $display("FAIL seq_instr got=%h exp=33333333", instr_d_o); end
    tests++; if (pc_d_o !== 32'hBFC0_0008 || pc_plus4_d_o !== 32'hBFC0_000C) begin fails++; $display("FAIL seq_pcd got=%h/%h exp=bfc00008/bfc0000c", pc_d_o, pc_plus4_d_o); end
    tests++; if (fetch_count_o !== 32'd3) begin fails++; $display("FAIL seq_count got=%0d exp=3", fetch_count_o); end
  endtask

  task automatic test_stall();
    do_reset();
    drive_edge(1'b0, 1'b0, 1'b0, 32'h0); void'(exp_q.pop_front());
    drive_edge(1'b0, 1'b0, 1'b0, 32'h0); void'(exp_q.pop_front());
    for (int i = 0; i < 2; i++) begin
      drive_edge(1'b1, 1'b0, 1'b0, 32'h0);
      e = exp_q.pop_front();
      tests++; if (obs !== e || instr_d_o !== 32'h2222_2222) begin fails++; $display("FAIL stall_hold[%0d] got=%h exp=%h", i, obs, e); end
      tests++; if (pc_f_o !== 32'hBFC0_0008 || fetch_count_o !== 32'd2) begin fails++; $display("FAIL stall_pc[%0d] got=%h/%0d exp=bfc00008/2", i, pc_f_o, fetch_count_o); end
    end
    drive_edge(1'b0, 1'b0, 1'b0, 32'h0);
    e = exp_q.pop_front();
    tests++; if (instr_d_o !== 32'h3333_3333 || obs !== e) begin fails++; $display("FAIL stall_release got=%h exp=33333333", instr_d_o); end
  endtask

  task automatic test_redirect_flush();
    drive_edge(1'b0, 1'b1, 1'b1, 32'hBFC0_0100);
    e = exp_q.pop_front();
    tests++; if (obs !== e || valid_d_o !== 1'b0 || instr_d_o !== 32'h13) begin fails++; $display("FAIL redir_bubble got=%h exp=%h", obs, e); end
    tests++; if (pc_f_o !== 32'hBFC0_0100) begin fails++; $display("FAIL redir_pc got=%h exp=bfc00100", pc_f_o); end
    drive_edge(1'b0, 1'b0, 1'b0, 32'h0);
    e = exp_q.pop_front();
    tests++; if (instr_d_o !== 32'hCAFE_0100 || pc_d_o !== 32'hBFC0_0100 || obs !== e) begin fails++; $display("FAIL redir_target got=%h/%h exp=cafe0100/bfc00100", instr_d_o, pc_d_o); end
  endtask

  task automatic test_simul();
    logic [31:0] held_pc;
    held_pc = pc_f_o;
    drive_edge(1'b1, 1'b1, 1'b0, 32'h0);
    e = exp_q.pop_front();
    tests++; if (obs !== e || valid_d_o !== 1'b0) begin fails++; $display("FAIL stallflush_ifid got=%h exp=%h", obs, e); end
    tests++; if (pc_f_o !== held_pc) begin fails++; $display("FAIL stallflush_pc got=%h exp=%h", pc_f_o, held_pc); end
    drive_edge(1'b1, 1'b0, 1'b1, 32'hBFC0_0200);
    e = exp_q.pop_front();
    tests++; if (pc_f_o !== 32'hBFC0_0200) begin fails++; $display("FAIL stallredir_pc got=%h exp=bfc00200", pc_f_o); end
    tests++; if (obs !== e) begin fails++; $display("FAIL stallredir_ifid got=%h exp=%h", obs, e); end
  endtask

  task automatic test_window();
    logic [31:0] cnt_before;
    drive_edge(1'b0, 1'b1, 1'b1, 32'hBFC0_0FFC); void'(exp_q.pop_front());
    drive_edge(1'b0, 1'b0, 1'b0, 32'h0);
    e = exp_q.pop_front();
    tests++; if (valid_d_o !== 1'b1 || instr_d_o !== 32'hDEAD_0FFC || obs !== e) begin fails++; $display("FAIL win_last got=%h exp=%h", obs, e); end
    tests++; if (pc_f_o !== 32'hBFC0_1000) begin fails++; $display("FAIL win_pc got=%h exp=bfc01000", pc_f_o); end
    cnt_before = fetch_count_o;
    drive_edge(1'b0, 1'b0, 1'b0, 32'h0);
    e = exp_q.pop_front();
    tests++; if (fault_d_o !== 1'b1 || valid_d_o !== 1'b0 || instr_d_o !== 32'h13 || pc_d_o !== 32'hBFC0_1000) begin fails++; $display("FAIL win_fault got=%h exp=%h", obs, e); end
    tests++; if (fetch_count_o !== cnt_before) begin fails++; $display("FAIL win_count got=%0d exp=%0d", fetch_count_o, cnt_before); end
    drive_edge(1'b1, 1'b0, 1'b0, 32'h0);
    e = exp_q.pop_front();
    tests++; if (obs !== e || fault_d_o !== 1'b1) begin fails++; $display("FAIL win_stall_fault got=%h exp=%h", obs, e); end
    drive_edge(1'b0, 1'b1, 1'b1, 32'hBFC0_0102); void'(exp_q.pop_front());
    drive_edge(1'b0, 1'b0, 1'b0, 32'h0);
    e = exp_q.pop_front();
    tests++; if (fault_d_o !== 1'b1 || pc_d_o !== 32'hBFC0_0102 || obs !== e) begin fails++; $display("FAIL misalign got=%h exp=%h", obs, e); end
    tests++; if (pc_f_o !== 32'hBFC0_0106) begin fails++; $display("FAIL misalign_pc got=%h exp=bfc00106", pc_f_o); end
  endtask

  task automatic test_back_to_back();
    logic        st, fl, rv;
    logic [31:0] rpc;
    do_reset();
    for (int i = 0; i < 300; i++) begin
      st = ($urandom_range(0, 4) == 0);
      fl = ($urandom_range(0, 7) == 0);
      rv = ($urandom_range(0, 7) == 0);
      rpc = 32'hBFC0_0000 | (32'($urandom_range(0, 1023)) << 2);
      if ($urandom_range(0, 9) == 0) rpc = rpc + 32'd2;
      if ($urandom_range(0, 9) == 0) rpc = rpc ^ 32'h0000_1000;
      drive_edge(st, fl, rv, rpc);
      e = exp_q.pop_front();
      tests++; if (obs !== e) begin fails++; $display("FAIL b2b_ifid[%0d] got=%h exp=%h", i, obs, e); end
      tests++; if (pc_f_o !== m_pc || fetch_count_o !== m_cnt) begin fails++; $display("FAIL b2b_state[%0d] got=%h/%0d exp=%h/%0d", i, pc_f_o, fetch_count_o, m_pc, m_cnt); end
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'hA500_0000 | 32'(i * 7);
    mem[0] = 32'h1111_1111;
    mem[1] = 32'h2222_2222;
    mem[2] = 32'h3333_3333;
    mem[64] = 32'hCAFE_0100;
    mem[1023] = 32'hDEAD_0FFC;
    rst_n = 1'b0;
    stall_i = 1'b0; flush_i = 1'b0; redirect_valid_i = 1'b0; redirect_pc_i = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_seq();
    test_stall();
    test_redirect_flush();
    test_simul();
    test_window();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
